// File: rtl/saa_write_sequencer.sv
// Write buffer in front of the SAA1099 core: queues CPU {a0, data} writes in order and
// replays each with a setup / strobe / hold / recovery sequence on the chip bus.
module saa_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int PULSE = 2,
  parameter int GAP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_wr,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_d,
  input  logic       ovf_clr,
  output logic       cpu_wait,
  output logic       overflow,
  output logic       busy,
  output logic       saa_wr_n,
  output logic       saa_a0,
  output logic [7:0] saa_d
);
  localparam int AW   = $clog2(DEPTH);
  localparam int MAXT = (PULSE > GAP) ? PULSE : GAP;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} state_t;

  logic [DEPTH-1:0][8:0] mem_q;
  logic [AW-1:0]         wp_q, rp_q;
  logic [AW:0]           cnt_q, cnt_d;
  state_t                state_q;
  logic [CW-1:0]         tmr_q;
  logic                  wr_n_q, a0_q, ovf_q;
  logic [7:0]            d_q;
  logic                  pop, push, drop;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a write then.
  assign pop  = (state_q == S_IDLE) && (cnt_q != '0);
  assign push = cpu_wr && ((cnt_q != FULL) || pop);
  assign drop = cpu_wr && !push;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {cpu_a0, cpu_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      wr_n_q  <= 1'b1;
      a0_q    <= 1'b0;
      d_q     <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: if (pop) begin
          a0_q    <= mem_q[rp_q][8];
          d_q     <= mem_q[rp_q][7:0];
          state_q <= S_SETUP;
        end
        S_SETUP: begin
          wr_n_q  <= 1'b0;
          tmr_q   <= CW'(PULSE - 1);
          state_q <= S_STROBE;
        end
        S_STROBE: if (tmr_q == '0) begin
          wr_n_q  <= 1'b1;
          state_q <= S_HOLD;
        end else tmr_q <= tmr_q - 1'b1;
        S_HOLD: if (GAP > 0) begin
          tmr_q   <= CW'((GAP > 0) ? GAP - 1 : 0);
          state_q <= S_GAP;
        end else state_q <= S_IDLE;
        S_GAP: if (tmr_q == '0) state_q <= S_IDLE;
               else tmr_q <= tmr_q - 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_wait = (cnt_q == FULL);
  assign overflow = ovf_q;
  assign busy     = (cnt_q != '0) || (state_q != S_IDLE);
  assign saa_wr_n = wr_n_q;
  assign saa_a0   = a0_q;
  assign saa_d    = d_q;
endmodule

// File: tb/tb_saa_write_sequencer.sv
// Directed bench: default-timing instance plus a PULSE=1/GAP=0 instance on a shared clock.
`timescale 1ns/1ps
module tb_saa_write_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic cpu_wr, cpu_a0, ovf_clr;
  logic [7:0] cpu_d;
  logic cpu_wait, overflow, busy, saa_wr_n, saa_a0;
  logic [7:0] saa_d;
  logic c1_wr, c1_a0, c1_clr;
  logic [7:0] c1_d;
  logic w1_wait, w1_ovf, w1_busy, w1_wr_n, w1_a0;
  logic [7:0] w1_d;

  int tests = 0, fails = 0;

  typedef struct {int c; logic a0; logic [7:0] d;} ev_t;
  ev_t  evq[$];
  logic prev_wr_n = 1'b1;
  bit   wait_seen = 1'b0;
  time  t0 = 0;

  saa_write_sequencer #(.DEPTH(4), .PULSE(2), .GAP(8)) u0 (
    .clk(clk), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_a0(cpu_a0), .cpu_d(cpu_d),
    .ovf_clr(ovf_clr), .cpu_wait(cpu_wait), .overflow(overflow), .busy(busy),
    .saa_wr_n(saa_wr_n), .saa_a0(saa_a0), .saa_d(saa_d));

  saa_write_sequencer #(.DEPTH(4), .PULSE(1), .GAP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .cpu_wr(c1_wr), .cpu_a0(c1_a0), .cpu_d(c1_d),
    .ovf_clr(c1_clr), .cpu_wait(w1_wait), .overflow(w1_ovf), .busy(w1_busy),
    .saa_wr_n(w1_wr_n), .saa_a0(w1_a0), .saa_d(w1_d));

  always #5 clk = ~clk;

  // Strobe falling-edge recorder; cycle index is relative to t0 (the cycle-0 drive time).
  always @(posedge clk) begin
    #2;
    if (prev_wr_n && !saa_wr_n)
      evq.push_back('{c: int'(($time - t0 - 1) / 10), a0: saa_a0, d: saa_d});
    prev_wr_n = saa_wr_n;
    if (cpu_wait) wait_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_wr = 0; cpu_a0 = 0; cpu_d = 0; ovf_clr = 0;
    c1_wr = 0; c1_a0 = 0; c1_d = 0; c1_clr = 0;
    #12;
    tests++;
    if ({saa_wr_n, saa_a0, saa_d, cpu_wait, overflow, busy} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_outputs: wr_n=%b a0=%b d=%h wait=%b ovf=%b busy=%b, want 1 0 00 0 0 0",
               saa_wr_n, saa_a0, saa_d, cpu_wait, overflow, busy);
    end
    tests++;
    if ({w1_wr_n, w1_busy} !== 2'b10) begin
      fails++; $display("FAIL reset_u1: wr_n=%b busy=%b, want 1 0", w1_wr_n, w1_busy);
    end
    #1 rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_single();
    t0 = $time;
    cpu_wr = 1; cpu_a0 = 1; cpu_d = 8'h1C;
    for (int c = 1; c <= 15; c++) begin
      tick();
      cpu_wr = 0;
      tests++;
      if (saa_wr_n !== !(c == 3 || c == 4)) begin
        fails++; $display("FAIL single_wr_n c%0d: got %b want %b", c, saa_wr_n, !(c == 3 || c == 4));
      end
      if (c >= 2) begin
        tests++;
        if ({saa_a0, saa_d} !== {1'b1, 8'h1C}) begin
          fails++; $display("FAIL single_data c%0d: got %b/%h want 1/1c", c, saa_a0, saa_d);
        end
      end
      if (c == 13 || c == 14) begin
        tests++;
        if (busy !== (c == 13)) begin
          fails++; $display("FAIL single_busy c%0d: got %b want %b", c, busy, c == 13);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] v [4];
    bit ok;
    v[0] = {1'b1, 8'h00}; v[1] = {1'b0, 8'h3F}; v[2] = {1'b1, 8'h1C}; v[3] = {1'b0, 8'h01};
    evq.delete(); wait_seen = 0;
    t0 = $time;
    for (int i = 0; i < 4; i++) begin
      cpu_wr = 1; {cpu_a0, cpu_d} = v[i];
      tick();
    end
    cpu_wr = 0;
    wait_idle(120, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: busy=%b want 0", busy); end
    tests++;
    if (evq.size() != 4) begin
      fails++; $display("FAIL b2b_count: got %0d strobes want 4", evq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (evq[i].c != 3 + 13*i || {evq[i].a0, evq[i].d} !== v[i]) begin
          fails++;
          $display("FAIL b2b_strobe%0d: cyc %0d %b/%h want cyc %0d %b/%h",
                   i, evq[i].c, evq[i].a0, evq[i].d, 3 + 13*i, v[i][8], v[i][7:0]);
        end
      end
    end
    tests++;
    if (wait_seen) begin fails++; $display("FAIL b2b_wait: cpu_wait asserted, want never"); end
  endtask

  task automatic test_overflow();
    bit ok;
    evq.delete();
    t0 = $time;
    cpu_wr = 1; cpu_a0 = 1; cpu_d = 8'h07;
    for (int c = 1; c <= 16; c++) begin
      tick();
      cpu_wr = (c >= 6 && c <= 11); cpu_a0 = 0; cpu_d = 8'(8'h10 + c - 6);
      if (c == 10) begin
        tests++;
        if ({cpu_wait, overflow} !== 2'b10) begin
          fails++; $display("FAIL ovf_full c10: wait/ovf %b%b want 10", cpu_wait, overflow);
        end
      end
      if (c == 12 || c == 14 || c == 15) begin
        tests++;
        if ({cpu_wait, overflow} !== {c != 15, 1'b1}) begin
          fails++; $display("FAIL ovf_state c%0d: wait/ovf %b%b want %b1", c, cpu_wait, overflow, c != 15);
        end
      end
    end
    ovf_clr = 1; tick(); ovf_clr = 0;
    tests++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    wait_idle(200, ok);
    tests++;
    if (!ok || evq.size() != 5) begin
      fails++; $display("FAIL ovf_drain: ok=%0d strobes=%0d want 1 5", ok, evq.size());
    end else begin
      tests++;
      if (evq[0].d !== 8'h07 || evq[1].d !== 8'h10 || evq[4].d !== 8'h13 || evq[4].a0 !== 1'b0) begin
        fails++; $display("FAIL ovf_order: got %h %h %h want 07 10 13", evq[0].d, evq[1].d, evq[4].d);
      end
    end
  endtask

  task automatic test_full_pushpop();
    bit ok;
    evq.delete();
    t0 = $time;
    cpu_wr = 1; cpu_a0 = 1; cpu_d = 8'h20;
    for (int c = 1; c <= 15; c++) begin
      tick();
      cpu_wr = (c >= 6 && c <= 9) || c == 14;
      cpu_a0 = 0;
      cpu_d = (c == 14) ? 8'hAA : 8'(8'h21 + c - 6);
      if (c == 14 || c == 15) begin
        tests++;
        if ({cpu_wait, overflow} !== 2'b10) begin
          fails++; $display("FAIL pushpop_full c%0d: wait/ovf %b%b want 10", c, cpu_wait, overflow);
        end
      end
    end
    cpu_wr = 0;
    wait_idle(200, ok);
    tests++;
    if (!ok || evq.size() != 6) begin
      fails++; $display("FAIL pushpop_drain: ok=%0d strobes=%0d want 1 6", ok, evq.size());
    end else begin
      tests++;
      if ({evq[5].a0, evq[5].d} !== {1'b0, 8'hAA} || evq[4].d !== 8'h24) begin
        fails++; $display("FAIL pushpop_last: got %b/%h prev %h want 0/aa prev 24", evq[5].a0, evq[5].d, evq[4].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    evq.delete();
    t0 = $time;
    for (int c = 1; c <= 16; c++) begin
      cpu_wr = (c <= 3); cpu_a0 = 0; cpu_d = 8'(8'h30 + c);
      tick();
    end
    cpu_wr = 0;
    tests++;
    if (saa_wr_n !== 1'b0 || saa_d !== 8'h32) begin
      fails++; $display("FAIL rmid_pre: wr_n=%b d=%h want 0 32", saa_wr_n, saa_d);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({saa_wr_n, saa_a0, saa_d, cpu_wait, overflow, busy} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL rmid_reset: wr_n=%b a0=%b d=%h wait=%b ovf=%b busy=%b, want 1 0 00 0 0 0",
               saa_wr_n, saa_a0, saa_d, cpu_wait, overflow, busy);
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    tests++;
    if (evq.size() != 2 || busy !== 1'b0) begin
      fails++; $display("FAIL rmid_noreplay: strobes=%0d busy=%b want 2 0", evq.size(), busy);
    end
  endtask

  task automatic test_gap0();
    for (int c = 1; c <= 14; c++) begin
      c1_wr = (c <= 3); c1_a0 = (c == 1); c1_d = 8'(8'h40 + c);
      tick();
      tests++;
      if (w1_wr_n !== !(c == 3 || c == 7 || c == 11)) begin
        fails++; $display("FAIL gap0_wr_n c%0d: got %b want %b", c, w1_wr_n, !(c == 3 || c == 7 || c == 11));
      end
      if (c == 3 || c == 11) begin
        tests++;
        if ({w1_a0, w1_d} !== ((c == 3) ? {1'b1, 8'h41} : {1'b0, 8'h43})) begin
          fails++; $display("FAIL gap0_data c%0d: got %b/%h", c, w1_a0, w1_d);
        end
      end
      if (c == 12 || c == 13) begin
        tests++;
        if (w1_busy !== (c == 12)) begin
          fails++; $display("FAIL gap0_busy c%0d: got %b want %b", c, w1_busy, c == 12);
        end
      end
    end
    c1_wr = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pushpop();
    test_reset_mid();
    test_gap0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
